// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared state encoding, packet framing constants and error codes
// for the FPU command sequencer.
package fpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT,
        ECHO
    } state_t;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;
    localparam int         PKT_BYTES   = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SQRT = 4'd4;
    localparam logic [3:0] OP_CMP  = 4'd5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SYNC    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

endpackage

// File: rtl/fpu_seq_watchdog.sv
// fpu_seq_watchdog: restartable cycle counter that flags expiry after
// TIMEOUT_CYCLES enabled cycles without a restart.
module fpu_seq_watchdog
    import fpu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_l,
    input  logic restart,
    input  logic enable,
    output logic expired
);
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt;

    // A restart in the same cycle always beats expiry, so a byte arriving
    // exactly at the limit is still accepted.
    assign expired = enable && !restart && cnt == LIMIT;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            cnt <= '0;
        else if (restart)
            cnt <= '0;
        else if (enable && cnt != LIMIT)
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer: turns 5-byte UART command packets into half-precision FPU
// issues and captures the result; define FPU_SEQ_ECHO_EN to echo results on tx_*.
module fpu_cmd_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_byte_i,
    output logic        fpu_start_o,
    output logic [3:0]  fpu_op_o,
    output logic [15:0] fpu_a_o,
    output logic [15:0] fpu_b_o,
    input  logic        fpu_done_i,
    input  logic [15:0] fpu_result_i,
    output logic [15:0] result_o,
    output logic        result_valid_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_byte_o,
    input  logic        tx_ready_i
);
    state_t     state;
    logic [2:0] idx;
    logic       sync_ok;
    logic       wd_restart;
    logic       wd_enable;
    logic       wd_expired;

    assign sync_ok    = rx_byte_i[7:4] == SYNC_NIBBLE;
    assign busy_o     = state != IDLE;
    assign wd_enable  = state == COLLECT || state == WAIT;
    assign wd_restart = (rx_valid_i && (state == IDLE ? sync_ok : state == COLLECT)) || state == ISSUE;

    fpu_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_l  (rst_l),
        .restart(wd_restart),
        .enable (wd_enable),
        .expired(wd_expired)
    );

`ifdef FPU_SEQ_ECHO_EN
    logic echo_lo;
`else
    logic unused_tx_ready;
    assign unused_tx_ready = tx_ready_i;
    assign tx_valid_o      = 1'b0;
    assign tx_byte_o       = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state          <= IDLE;
            idx            <= '0;
            fpu_start_o    <= 1'b0;
            fpu_op_o       <= '0;
            fpu_a_o        <= '0;
            fpu_b_o        <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            err_o          <= 1'b0;
            err_code_o     <= ERR_NONE;
`ifdef FPU_SEQ_ECHO_EN
            echo_lo        <= 1'b0;
            tx_valid_o     <= 1'b0;
            tx_byte_o      <= '0;
`endif
        end else begin
            fpu_start_o    <= 1'b0;
            result_valid_o <= 1'b0;
            err_o          <= 1'b0;
            err_code_o     <= ERR_NONE;
            // Bytes arriving while a packet is in flight are dropped, not queued.
            if (rx_valid_i && state != IDLE && state != COLLECT) begin
                err_o      <= 1'b1;
                err_code_o <= ERR_OVERRUN;
            end
            case (state)
                IDLE: begin
                    if (rx_valid_i) begin
                        if (sync_ok) begin
                            fpu_op_o <= rx_byte_i[3:0];
                            idx      <= 3'd1;
                            state    <= COLLECT;
                        end else begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_SYNC;
                        end
                    end
                end
                COLLECT: begin
                    if (rx_valid_i) begin
                        fpu_a_o <= idx == 3'd1 ? {rx_byte_i, fpu_a_o[7:0]} :
                                   idx == 3'd2 ? {fpu_a_o[15:8], rx_byte_i} : fpu_a_o;
                        fpu_b_o <= idx == 3'd3 ? {rx_byte_i, fpu_b_o[7:0]} :
                                   idx == 3'd4 ? {fpu_b_o[15:8], rx_byte_i} : fpu_b_o;
                        if (idx == 3'(PKT_BYTES - 1)) begin
                            idx         <= '0;
                            fpu_start_o <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else if (wd_expired) begin
                        err_o      <= 1'b1;
                        err_code_o <= ERR_TIMEOUT;
                        idx        <= '0;
                        state      <= IDLE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (fpu_done_i) begin
                        result_o       <= fpu_result_i;
                        result_valid_o <= 1'b1;
`ifdef FPU_SEQ_ECHO_EN
                        tx_valid_o     <= 1'b1;
                        tx_byte_o      <= fpu_result_i[15:8];
                        echo_lo        <= 1'b0;
                        state          <= ECHO;
`else
                        state          <= IDLE;
`endif
                    end else if (wd_expired) begin
                        err_o      <= 1'b1;
                        err_code_o <= ERR_TIMEOUT;
                        state      <= IDLE;
                    end
                end
`ifdef FPU_SEQ_ECHO_EN
                ECHO: begin
                    if (tx_valid_o && tx_ready_i) begin
                        if (echo_lo) begin
                            tx_valid_o <= 1'b0;
                            tx_byte_o  <= '0;
                            state      <= IDLE;
                        end else begin
                            tx_byte_o <= result_o[7:0];
                            echo_lo   <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// tb_fpu_cmd_sequencer: scoreboard bench; stimulus pushes expected FPU issues,
// results, errors and echo bytes, a negedge monitor pops and compares them.
module tb_fpu_cmd_sequencer;
    localparam int T = 16;

    typedef struct {
        logic [35:0] val;
        int          lo;
        int          hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_byte_i = '0;
    logic        fpu_start_o;
    logic [3:0]  fpu_op_o;
    logic [15:0] fpu_a_o;
    logic [15:0] fpu_b_o;
    logic        fpu_done_i = 1'b0;
    logic [15:0] fpu_result_i = '0;
    logic [15:0] result_o;
    logic        result_valid_o;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic        tx_valid_o;
    logic [7:0]  tx_byte_o;
    logic        tx_ready_i = 1'b0;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    exp_t q_start[$];
    exp_t q_res[$];
    exp_t q_err[$];
    exp_t q_tx[$];
    logic tx_seen = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_byte = '0;

    fpu_cmd_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .rx_valid_i    (rx_valid_i),
        .rx_byte_i     (rx_byte_i),
        .fpu_start_o   (fpu_start_o),
        .fpu_op_o      (fpu_op_o),
        .fpu_a_o       (fpu_a_o),
        .fpu_b_o       (fpu_b_o),
        .fpu_done_i    (fpu_done_i),
        .fpu_result_i  (fpu_result_i),
        .result_o      (result_o),
        .result_valid_o(result_valid_o),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .err_code_o    (err_code_o),
        .tx_valid_o    (tx_valid_o),
        .tx_byte_o     (tx_byte_o),
        .tx_ready_i    (tx_ready_i)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [35:0] act, logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_win(string name, int lo, int hi);
        tests++;
        if (cyc < lo || cyc > hi) begin
            fails++;
            $display("FAIL %s: got cycle %0d, expected %0d..%0d", name, cyc, lo, hi);
        end
    endtask

    task automatic unexpected(string name);
        tests++;
        fails++;
        $display("FAIL %s: got an unexpected pulse at cycle %0d, expected none", name, cyc);
    endtask

    task automatic push(int k, logic [35:0] v, int lo, int hi);
        exp_t e;
        e.val = v;
        e.lo  = lo;
        e.hi  = hi;
        case (k)
            0: q_start.push_back(e);
            1: q_res.push_back(e);
            2: q_err.push_back(e);
            default: q_tx.push_back(e);
        endcase
    endtask

    // Monitor: every DUT pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_l) begin
            if (fpu_start_o) begin
                if (q_start.size() == 0) unexpected("start");
                else begin
                    e = q_start.pop_front();
                    check("start_op_a_b", {fpu_op_o, fpu_a_o, fpu_b_o}, e.val);
                    check_win("start_cycle", e.lo, e.hi);
                end
            end
            if (result_valid_o) begin
                if (q_res.size() == 0) unexpected("result_valid");
                else begin
                    e = q_res.pop_front();
                    check("result", {20'h0, result_o}, e.val);
                    check_win("result_cycle", e.lo, e.hi);
                end
            end
            if (err_o) begin
                if (q_err.size() == 0) unexpected("err");
                else begin
                    e = q_err.pop_front();
                    check("err_code", {34'h0, err_code_o}, e.val);
                    check_win("err_cycle", e.lo, e.hi);
                end
            end
`ifdef FPU_SEQ_ECHO_EN
            if (prev_stall) check("tx_hold", {28'h0, tx_byte_o}, {28'h0, prev_byte});
            if (tx_valid_o && tx_ready_i) begin
                if (q_tx.size() == 0) unexpected("tx");
                else begin
                    e = q_tx.pop_front();
                    check("tx_byte", {28'h0, tx_byte_o}, e.val);
                end
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_byte  = tx_byte_o;
`else
            if (tx_valid_o || tx_byte_o != 8'h00) tx_seen = 1'b1;
`endif
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        tx_ready_i = $urandom_range(0, 2) != 0;
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit: got no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic send(logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_byte_i  = b;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy_o; i++) tick();
        check("back_to_idle", {35'h0, busy_o}, 36'h0);
    endtask

    task automatic send_pkt(logic [3:0] op, logic [15:0] a, logic [15:0] b, int gap);
        send({4'hA, op});
        idle($urandom_range(0, gap)); send(a[15:8]);
        idle($urandom_range(0, gap)); send(a[7:0]);
        idle($urandom_range(0, gap)); send(b[15:8]);
        idle($urandom_range(0, gap)); send(b[7:0]);
        push(0, {op, a, b}, cyc, cyc);
    endtask

    task automatic finish_done(logic [15:0] r, logic ov);
        idle($urandom_range(1, 4));
        fpu_done_i   = 1'b1;
        fpu_result_i = r;
        rx_valid_i   = ov;
        rx_byte_i    = 8'($urandom);
        tick();
        fpu_done_i = 1'b0;
        rx_valid_i = 1'b0;
        push(1, {20'h0, r}, cyc, cyc);
        if (ov) push(2, 36'h3, cyc, cyc);
`ifdef FPU_SEQ_ECHO_EN
        push(3, {28'h0, r[15:8]}, 0, 0);
        push(3, {28'h0, r[7:0]}, 0, 0);
`endif
        wait_idle();
        check("result_hold", {20'h0, result_o}, {20'h0, r});
    endtask

    task automatic collect_timeout(int k);
        send({4'hA, 4'($urandom)});
        for (int i = 0; i < k; i++) send(8'($urandom));
        push(2, 36'h2, cyc + T - 1, cyc + T + 2);
        idle(T + 4);
        check("timeout_idle", {35'h0, busy_o}, 36'h0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [7:0]  bad;
        logic [15:0] a;
        logic [15:0] b;
        idle(2);
        check("rst_busy", {35'h0, busy_o}, 36'h0);
        check("rst_result", {20'h0, result_o}, 36'h0);
        check("rst_pulses", {33'h0, fpu_start_o, result_valid_o, err_o}, 36'h0);
        check("rst_operands", {fpu_op_o, fpu_a_o, fpu_b_o}, 36'h0);
        rst_l = 1'b1;
        tick();

        send_pkt(4'h1, 16'h3C00, 16'h4000, 0);
        finish_done(16'h3E00, 1'b0);

        send(8'h51);
        push(2, 36'h1, cyc, cyc);
        check("bad_sync_busy", {35'h0, busy_o}, 36'h0);

        send(8'hA0);
        check("collect_busy", {35'h0, busy_o}, 36'h1);
        send(8'h3C);
        push(2, 36'h2, cyc + T - 1, cyc + T + 2);
        idle(T + 4);
        check("timeout_idle", {35'h0, busy_o}, 36'h0);

        send_pkt(4'h2, 16'h4200, 16'h4400, 1);
        idle(1);
        send(8'hA5);
        push(2, 36'h3, cyc, cyc);
        finish_done(16'h4A00, 1'b0);

        send_pkt(4'h3, 16'h1234, 16'h5678, 0);
        idle(2);
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        fpu_done_i   = 1'b1;
        fpu_result_i = 16'hBEEF;
        tick();
        fpu_done_i = 1'b0;
        idle(2);
        check("rst_wait_result", {20'h0, result_o}, 36'h0);
        check("rst_wait_busy", {35'h0, busy_o}, 36'h0);

        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom);
            a  = 16'($urandom);
            b  = 16'($urandom);
            case ($urandom_range(0, 9))
                0: begin
                    bad = 8'($urandom);
                    if (bad[7:4] == 4'hA) bad[7:4] = 4'h5;
                    send(bad);
                    push(2, 36'h1, cyc, cyc);
                end
                1: collect_timeout($urandom_range(0, 3));
                2: begin
                    send_pkt(op, a, b, 3);
                    push(2, 36'h2, cyc + T, cyc + T + 3);
                    idle(T + 5);
                    check("wait_timeout_idle", {35'h0, busy_o}, 36'h0);
                end
                3: begin
                    fpu_done_i   = 1'b1;
                    fpu_result_i = a;
                    tick();
                    fpu_done_i = 1'b0;
                    idle(1);
                end
                default: begin
                    send_pkt(op, a, b, 3);
                    if ($urandom_range(0, 2) == 0) begin
                        idle(1);
                        send(8'($urandom));
                        push(2, 36'h3, cyc, cyc);
                    end
                    finish_done(16'($urandom), $urandom_range(0, 3) == 0);
                end
            endcase
            idle($urandom_range(0, 2));
        end

        idle(4);
        check("q_start_empty", 36'(q_start.size()), 36'h0);
        check("q_res_empty", 36'(q_res.size()), 36'h0);
        check("q_err_empty", 36'(q_err.size()), 36'h0);
`ifdef FPU_SEQ_ECHO_EN
        check("q_tx_empty", 36'(q_tx.size()), 36'h0);
`else
        check("tx_tied_low", {35'h0, tx_seen}, 36'h0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
